music_sequencer: RTL
====================

Name: music_sequencer

Overview:
- Program sequencer for the music CPU. Owns the song PC and fetches instructions from the SRAM.
- Executes the control instructions itself: BPM, repeat-high, repeat/loop and end.
- Hands note instructions one at a time to the note-player datapath over a valid/ready handshake.
- Replaces the ad-hoc fetch/repeat logic in the player. The player now only consumes notes and BPM.

Parameters:
- START_ADDR, 18'hff00, PC value loaded on reset and on start.
- READ_WAIT, 2, SRAM read wait cycles (min 1) between address stable and data sampled.
- LEVELS, 8, number of nested repeat levels. It equals the range of the 3-bit level field.
- DEFAULT_BPM, 96, bpm_o value after reset and start.

Ports:
- CLK  in  1  50 MHz system clock
- RST  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse: (re)start the song at START_ADDR
- SRAM_A  out  18  SRAM address, always equal to pc
- SRAM_D  in  16  SRAM read data
- ins_o  out  16  note instruction offered to the player
- ins_valid  out  1  ins_o holds a note
- ins_ready  in  1  player accepts ins_o this cycle
- bpm_o  out  12  current tempo
- busy  out  1  sequencer is running (not IDLE/DONE)
- done  out  1  end instruction reached
- err  out  1  single-cycle pulse on an illegal opcode
- pc_o  out  18  debug copy of pc

Behaviour:
- Reset values:
  - state IDLE, pc=START_ADDR, ins_o=0, ins_valid=0, bpm_o=DEFAULT_BPM, busy=0, done=0, err=0.
  - hi_reg=0 and all repeat counters = 0.
- States: IDLE, FETCH, DECODE, HOLD, DONE.
- IDLE: waits for start.
- start pulse, accepted in any state:
  - pc<=START_ADDR, counters<=0, hi_reg<=0, bpm_o<=DEFAULT_BPM.
  - ins_valid<=0, done<=0, next state FETCH.
  - start has priority over every other transition. RST has priority over start.
- FETCH:
  - Hold pc for READ_WAIT cycles.
  - On the last cycle, latch SRAM_D into ir, then go to DECODE.
- DECODE (1 cycle), acting on ir:
  - ir[15]=1 (note): ins_o<=ir, ins_valid<=1, go to HOLD.
  - ir[15:12]=0000 (end): done<=1, go to DONE. pc is not incremented.
  - 0001 (bpm): bpm_o<=ir[11:0], pc<=pc+1, go to FETCH.
  - 0010 (rep-hi): hi_reg<=ir[11:0], pc<=pc+1, go to FETCH.
  - 0011 (repeat): fields and target:
    - lo=ir[11:6], N=ir[5:3], L=ir[2:0], target={hi_reg,lo}.
    - If cnt[L]==0 and N==0: pc+1.
    - If cnt[L]==0 and N!=0: cnt[L]<=N, pc<=target.
    - If cnt[L]==1: cnt[L]<=0, pc+1.
    - Otherwise: cnt[L]<=cnt[L]-1, pc<=target.
    - Net effect: the body executes N+1 times and the counter is left at 0 for re-entry.
  - 0100..0111 (illegal): err pulses for 1 cycle, pc<=pc+1, go to FETCH.
- HOLD:
  - ins_o is stable while ins_valid=1 and ins_ready=0.
  - On ins_valid&&ins_ready: ins_valid<=0, pc<=pc+1, go to FETCH.
- DONE: done=1 and held until start or RST.
- busy=1 in FETCH, DECODE and HOLD.
- Arithmetic:
  - pc+1 wraps modulo 2^18.
  - Repeat counters are 3-bit and never underflow; the case analysis above makes this impossible.
- Latency:
  - From entering FETCH to ins_valid high: READ_WAIT+1 cycles.
  - A non-note instruction costs READ_WAIT+1 cycles.
  - From note accept to the next fetch: 1 cycle.
- ins_ready while ins_valid=0 is ignored.
- RST mid-operation returns all state to the reset values on the next edge.

Optional Feature:
- Macro: SEQ_LOOP_GUARD_EN.
- Defined:
  - A 10-bit counter counts consecutive non-note instructions decoded. Delivering a note clears it, as do start and RST.
  - When it reaches 1023, the sequencer forces DONE: done=1 and a 1-cycle err pulse. This catches note-less infinite loops.
- Not defined: no counter; a note-less loop runs forever with busy=1.

Test Plan:
- Linear song:
  - Stimulus: ff00=8123, ff01=1078, ff02=8456, ff03=0000; start, ins_ready always 1.
  - Expected: ins_o 8123 then 8456; bpm_o=0x078 before the second note; done=1, busy=0, pc_o=ff03.
- Single repeat:
  - Stimulus: ff00=23FC (hi=0x3FC), ff01=8A11, ff02=3010 (lo=0, N=2, L=0), ff03=0000.
  - Expected: 8A11 is delivered exactly 3 times, then done; cnt[0]=0 at the end.
- Nested repeats: inner L=1 N=1 inside outer L=0 N=1 → inner note delivered 4 times, outer-only note 2 times, then done.
- Backpressure:
  - Stimulus: hold ins_ready=0 for 100 cycles during HOLD.
  - Expected: ins_o, ins_valid and pc_o are unchanged throughout; one accept advances pc by 1.
- Reset and restart:
  - RST during HOLD → next cycle ins_valid=0, bpm_o=96, pc_o=ff00, IDLE.
  - start while busy → same pc and bpm_o result, with counters cleared and FETCH re-entered.
- Illegal opcode and guard:
  - 5000 at ff01 → 1-cycle err pulse and execution continues at ff02.
  - With SEQ_LOOP_GUARD_EN, a loop of only BPM/repeat instructions reaches done=1 after 1023 decodes.

Source files
------------

// File: rtl/music_sequencer.sv
// Song program sequencer: fetches from SRAM, executes tempo/repeat/end control words, offers notes to the player.
// Optional build macro SEQ_LOOP_GUARD_EN: forces DONE after 1023 consecutive non-note decodes.
module music_sequencer #(
  parameter logic [17:0] START_ADDR  = 18'hff00,
  parameter int          READ_WAIT   = 2,
  parameter int          LEVELS      = 8,
  parameter logic [11:0] DEFAULT_BPM = 12'd96
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  output logic [17:0] SRAM_A,
  input  logic [15:0] SRAM_D,
  output logic [15:0] ins_o,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [11:0] bpm_o,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [17:0] pc_o
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_HOLD, S_DONE} state_t;
  localparam logic [7:0] WAIT_LAST = 8'(READ_WAIT - 1);

  state_t      r_state, w_state_next;
  logic [17:0] r_pc, w_pc_next;
  logic [15:0] r_ir, w_ir_next;
  logic [7:0]  r_wait, w_wait_next;
  logic [15:0] r_ins, w_ins_next;
  logic        r_valid, w_valid_next;
  logic [11:0] r_bpm, w_bpm_next;
  logic [11:0] r_hi, w_hi_next;
  logic        r_done, w_done_next;
  logic        r_err, w_err_next;
  logic [2:0]  r_cnt [LEVELS];
  logic        w_cnt_we, w_cnt_clr;
  logic [2:0]  w_cnt_wdata;

  logic [2:0]  w_lvl, w_n, w_cnt_cur;
  logic [5:0]  w_lo;
  logic [17:0] w_target, w_pc_inc;

`ifdef SEQ_LOOP_GUARD_EN
  logic [9:0]  r_guard, w_guard_next;
`endif

  assign w_lvl     = r_ir[2:0];
  assign w_n       = r_ir[5:3];
  assign w_lo      = r_ir[11:6];
  assign w_target  = {r_hi, w_lo};
  assign w_cnt_cur = r_cnt[w_lvl];
  assign w_pc_inc  = r_pc + 18'd1;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    w_wait_next  = r_wait;
    w_ins_next   = r_ins;
    w_valid_next = r_valid;
    w_bpm_next   = r_bpm;
    w_hi_next    = r_hi;
    w_done_next  = r_done;
    w_err_next   = 1'b0;
    w_cnt_we     = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_wdata  = 3'd0;
`ifdef SEQ_LOOP_GUARD_EN
    w_guard_next = r_guard;
`endif
    case (r_state)
      S_IDLE: ;
      S_FETCH: begin
        if (r_wait == WAIT_LAST) begin
          w_ir_next    = SRAM_D;
          w_wait_next  = 8'd0;
          w_state_next = S_DECODE;
        end else begin
          w_wait_next = r_wait + 8'd1;
        end
      end
      S_DECODE: begin
        w_state_next = S_FETCH;
        if (r_ir[15]) begin
          w_ins_next   = r_ir;
          w_valid_next = 1'b1;
          w_state_next = S_HOLD;
        end else begin
          case (r_ir[14:12])
            3'b000: begin
              w_done_next  = 1'b1;
              w_state_next = S_DONE;
            end
            3'b001: begin
              w_bpm_next = r_ir[11:0];
              w_pc_next  = w_pc_inc;
            end
            3'b010: begin
              w_hi_next = r_ir[11:0];
              w_pc_next = w_pc_inc;
            end
            3'b011: begin
              // Counter reloads with N on first arrival and returns to 0 on exit, so the body runs N+1 times
              if (w_cnt_cur == 3'd0) begin
                if (w_n == 3'd0) begin
                  w_pc_next = w_pc_inc;
                end else begin
                  w_cnt_we    = 1'b1;
                  w_cnt_wdata = w_n;
                  w_pc_next   = w_target;
                end
              end else if (w_cnt_cur == 3'd1) begin
                w_cnt_we  = 1'b1;
                w_pc_next = w_pc_inc;
              end else begin
                w_cnt_we    = 1'b1;
                w_cnt_wdata = w_cnt_cur - 3'd1;
                w_pc_next   = w_target;
              end
            end
            default: begin
              w_err_next = 1'b1;
              w_pc_next  = w_pc_inc;
            end
          endcase
        end
      end
      S_HOLD: begin
        if (r_valid && ins_ready) begin
          w_valid_next = 1'b0;
          w_pc_next    = w_pc_inc;
          w_state_next = S_FETCH;
        end
      end
      S_DONE: ;
      default: w_state_next = S_IDLE;
    endcase
`ifdef SEQ_LOOP_GUARD_EN
    if (r_state == S_DECODE) begin
      if (r_ir[15]) begin
        w_guard_next = 10'd0;
      end else if (r_guard == 10'd1022) begin
        w_guard_next = 10'd1023;
        w_done_next  = 1'b1;
        w_err_next   = 1'b1;
        w_state_next = S_DONE;
      end else begin
        w_guard_next = r_guard + 10'd1;
      end
    end
`endif
    if (start) begin
      w_pc_next    = START_ADDR;
      w_cnt_clr    = 1'b1;
      w_cnt_we     = 1'b0;
      w_hi_next    = 12'd0;
      w_bpm_next   = DEFAULT_BPM;
      w_valid_next = 1'b0;
      w_done_next  = 1'b0;
      w_err_next   = 1'b0;
      w_wait_next  = 8'd0;
      w_state_next = S_FETCH;
`ifdef SEQ_LOOP_GUARD_EN
      w_guard_next = 10'd0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_pc    <= START_ADDR;
      r_ir    <= 16'd0;
      r_wait  <= 8'd0;
      r_ins   <= 16'd0;
      r_valid <= 1'b0;
      r_bpm   <= DEFAULT_BPM;
      r_hi    <= 12'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef SEQ_LOOP_GUARD_EN
      r_guard <= 10'd0;
`endif
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
      r_wait  <= w_wait_next;
      r_ins   <= w_ins_next;
      r_valid <= w_valid_next;
      r_bpm   <= w_bpm_next;
      r_hi    <= w_hi_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
`ifdef SEQ_LOOP_GUARD_EN
      r_guard <= w_guard_next;
`endif
    end
    for (int i = 0; i < LEVELS; i++) begin
      if (RST || w_cnt_clr) begin
        r_cnt[i] <= 3'd0;
      end else if (w_cnt_we && (w_lvl == 3'(i))) begin
        r_cnt[i] <= w_cnt_wdata;
      end
    end
  end

  assign SRAM_A    = r_pc;
  assign pc_o      = r_pc;
  assign ins_o     = r_ins;
  assign ins_valid = r_valid;
  assign bpm_o     = r_bpm;
  assign done      = r_done;
  assign err       = r_err;
  assign busy      = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_HOLD);
endmodule
